// File: rtl/regfile_pkg.sv
// Shared constants and types for the 2-write / 2-read register file with scoreboard.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int ZERO_ADDR  = 0;

  // Write-port bundle at the default geometry.
  typedef struct packed {
    logic                  we;
    logic [DEF_ADDR_W-1:0] wa;
    logic [DEF_DATA_W-1:0] wd;
  } wr_port_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by reserve, cleared by write.
// Reserve beats a same-cycle write because it represents a newer producer.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter bit ZERO_REG = 1'b1,
  localparam int NREGS   = 2**ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rsv_en,
  input  logic [ADDR_W-1:0]      rsv_addr,
  input  logic [1:0]             clr_en,
  input  logic [1:0][ADDR_W-1:0] clr_addr,
  input  logic [1:0][ADDR_W-1:0] ra,
  output logic [1:0]             busy,
  output logic                   any_busy
);

  logic [NREGS-1:0] pending, pending_nxt;
  logic             rsv_ok;

  assign rsv_ok = rsv_en && !(ZERO_REG && (rsv_addr == ADDR_W'(ZERO_ADDR)));

  // Next pending state: clears first, then reserve so it wins on collision.
  always_comb begin
    pending_nxt = pending;
    for (int p = 0; p < 2; p++)
      if (clr_en[p]) pending_nxt[clr_addr[p]] = 1'b0;
    if (rsv_ok) pending_nxt[rsv_addr] = 1'b1;
  end

  // Pending register with synchronous clear.
  always_ff @(posedge clk) begin
    if (!rst_n) pending <= '0;
    else        pending <= pending_nxt;
  end

  // Busy lookup per read port.
  always_comb begin
    for (int r = 0; r < 2; r++) busy[r] = pending[ra[r]];
  end

  assign any_busy = |pending;

endmodule

// File: rtl/regfile_2w2r_sb.sv
// Register file: 2 synchronous write ports, 2 combinational read ports, optional
// hard-wired zero register and a pending-write scoreboard for RAW detection.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to the read ports.
module regfile_2w2r_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic              busy1,
  output logic              busy2,
  input  logic              we0,
  input  logic [ADDR_W-1:0] wa0,
  input  logic [DATA_W-1:0] wd0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [DATA_W-1:0] wd1,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              any_busy
);

  localparam int NREGS = 2**ADDR_W;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
  } wr_t;

  logic [NREGS-1:0][DATA_W-1:0] regs;
  wr_t  [1:0]                   wp;
  logic [1:0]                   wp_en;
  logic [1:0][ADDR_W-1:0]       wp_addr;
  logic [1:0][ADDR_W-1:0]       ra_v;
  logic [1:0][DATA_W-1:0]       rd_v;
  logic [1:0]                   sb_busy, busy_v;

  assign ra_v = {ra2, ra1};

  // Effective write ports; zero-register writes are dropped here so neither
  // storage, scoreboard nor bypass ever sees them.
  always_comb begin
    wp[0] = '{we: we0, wa: wa0, wd: wd0};
    wp[1] = '{we: we1, wa: wa1, wd: wd1};
    for (int p = 0; p < 2; p++) begin
      if (ZERO_REG && (wp[p].wa == ADDR_W'(ZERO_ADDR))) wp[p].we = 1'b0;
      wp_en[p]   = wp[p].we;
      wp_addr[p] = wp[p].wa;
    end
  end

  // Storage; port 1 is applied last so it wins an address collision.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs <= '0;
    end else begin
      for (int p = 0; p < 2; p++)
        if (wp[p].we) regs[wp[p].wa] <= wp[p].wd;
    end
  end

  regfile_scoreboard #(.ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .clr_en   (wp_en),
    .clr_addr (wp_addr),
    .ra       (ra_v),
    .busy     (sb_busy),
    .any_busy (any_busy)
  );

  for (genvar r = 0; r < 2; r++) begin : g_rd
    logic [DATA_W-1:0] rd_l;
    logic              busy_l;
    // Read mux, with same-cycle forwarding when the bypass is built in.
    always_comb begin
      rd_l   = regs[ra_v[r]];
      busy_l = sb_busy[r];
`ifdef REGFILE_BYPASS_EN
      for (int p = 0; p < 2; p++) begin
        if (wp[p].we && (wp[p].wa == ra_v[r])) begin
          rd_l = wp[p].wd;
          if (!(rsv_en && (rsv_addr == ra_v[r]))) busy_l = 1'b0;
        end
      end
`endif
    end
    assign rd_v[r]   = rd_l;
    assign busy_v[r] = busy_l;
  end

  assign rd1   = rd_v[0];
  assign rd2   = rd_v[1];
  assign busy1 = busy_v[0];
  assign busy2 = busy_v[1];

endmodule

// File: tb/tb_regfile_2w2r_sb.sv
// Directed bench for regfile_2w2r_sb; expectations follow REGFILE_BYPASS_EN if defined.
module tb_regfile_2w2r_sb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  ra1, ra2, wa0, wa1, rsv_addr;
  logic [31:0] rd1, rd2, wd0, wd1;
  logic        busy1, busy2, we0, we1, rsv_en, any_busy;

  int n_chk = 0;
  int n_pass = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  regfile_2w2r_sb dut (
    .clk(clk), .rst_n(rst_n),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2), .busy1(busy1), .busy2(busy2),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .any_busy(any_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
  endtask

  // Let the edge happen, then settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we0 = 0; we1 = 0; rsv_en = 0;
    wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0; rsv_addr = 0;
  endtask

  task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
    if (p == 0) begin we0 = 1; wa0 = a; wd0 = d; end
    else        begin we1 = 1; wa1 = a; wd1 = d; end
  endtask

  task automatic rsv(input logic [4:0] a);
    rsv_en = 1; rsv_addr = a;
  endtask

  initial begin
    idle(); ra1 = 0; ra2 = 0;
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
    ra1 = 5; #1;
    chk("rst_rd1", rd1, 0);
    chk("rst_any_busy", {31'b0, any_busy}, 0);

    // Load r5, reserve r6, then reset with a competing write/reserve.
    wr(0, 5, 32'hDEADBEEF); rsv(6); tick(); idle(); #1;
    chk("pre_rst_rd1", rd1, 32'hDEADBEEF);
    chk("pre_rst_any", {31'b0, any_busy}, 1);
    rst_n = 0; wr(0, 5, 32'h77); rsv(7); tick(); rst_n = 1; idle(); ra2 = 6; #1;
    chk("post_rst_rd1", rd1, 0);
    chk("post_rst_any", {31'b0, any_busy}, 0);
    chk("post_rst_busy2", {31'b0, busy2}, 0);

    // Dual write to distinct addresses.
    wr(0, 3, 32'h11); wr(1, 4, 32'h22); tick(); idle(); ra1 = 3; ra2 = 4; #1;
    chk("dual_rd1", rd1, 32'h11);
    chk("dual_rd2", rd2, 32'h22);

    // Same-address collision: port 1 wins.
    wr(0, 7, 32'hAAAA); wr(1, 7, 32'h5555); tick(); idle(); ra1 = 7; #1;
    chk("conflict_r7", rd1, 32'h5555);

    // Zero register ignores writes and reserves.
    wr(0, 0, 32'hFFFFFFFF); rsv(0); tick(); idle(); ra1 = 0; #1;
    chk("zero_rd1", rd1, 0);
    chk("zero_busy1", {31'b0, busy1}, 0);
    chk("zero_any", {31'b0, any_busy}, 0);

    // Scoreboard: reserve, write clears, reserve+write keeps pending.
    ra1 = 9; rsv(9); #1;
    chk("rsv_lat_busy1", {31'b0, busy1}, 0);
    tick(); idle(); #1;
    chk("rsv_busy1", {31'b0, busy1}, 1);
    chk("rsv_any", {31'b0, any_busy}, 1);
    wr(1, 9, 32'h1234); tick(); idle(); #1;
    chk("wr_clr_busy1", {31'b0, busy1}, 0);
    chk("wr_clr_rd1", rd1, 32'h1234);
    wr(0, 9, 32'h99); rsv(9); tick(); idle(); #1;
    chk("rsv_wr_busy1", {31'b0, busy1}, 1);
    chk("rsv_wr_rd1", rd1, 32'h99);
    rsv(9); tick(); idle(); #1;
    chk("re_rsv_busy1", {31'b0, busy1}, 1);
    wr(0, 9, 32'h9A); tick(); idle(); #1;
    chk("clr2_busy1", {31'b0, busy1}, 0);
    chk("clr2_any", {31'b0, any_busy}, 0);

    // Write to a non-pending register.
    wr(1, 10, 32'hCAFE); tick(); idle(); ra2 = 10; #1;
    chk("np_rd2", rd2, 32'hCAFE);
    chk("np_busy2", {31'b0, busy2}, 0);

    // Read during write: forwarded only when the bypass is built in.
    wr(0, 2, 32'h1); tick(); idle();
    ra1 = 2; wr(0, 2, 32'h2); #1;
    chk("rdw_same_cycle", rd1, BYP ? 32'h2 : 32'h1);
    tick(); idle(); #1;
    chk("rdw_next_cycle", rd1, 32'h2);

    // Busy during the clearing write, with and without a colliding reserve.
    rsv(11); tick(); idle(); ra2 = 11;
    wr(1, 11, 32'hB0B); #1;
    chk("byp_busy2", {31'b0, busy2}, BYP ? 0 : 1);
    rsv(11); #1;
    chk("byp_busy2_rsv", {31'b0, busy2}, 1);
    tick(); idle(); #1;
    chk("byp_busy2_after", {31'b0, busy2}, 1);
    wr(0, 11, 32'h0); tick(); idle(); #1;
    chk("byp_busy2_clr", {31'b0, busy2}, 0);

    // Double match: port 1 data forwarded; old value otherwise.
    ra1 = 12; wr(0, 12, 32'h111); wr(1, 12, 32'h222); #1;
    chk("byp_double", rd1, BYP ? 32'h222 : 32'h0);
    tick(); idle(); #1;
    chk("double_after", rd1, 32'h222);

    // Zero register never forwarded.
    ra1 = 0; wr(0, 0, 32'h5); #1;
    chk("byp_zero", rd1, 0);
    tick(); idle(); #1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
